// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control, preset and display signals of the countdown timer
interface countdown_timer_if;
    logic       tick;
    logic       load;
    logic [6:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       pause;
    logic       clear;
    logic [1:0] state;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       done;
    logic       alarm;

    modport master (
        output tick, load, load_min, load_sec, start, pause, clear,
        input  state, min_tens, min_ones, sec_tens, sec_ones, done, alarm
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, pause, clear,
        output state, min_tens, min_ones, sec_tens, sec_ones, done, alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable MM:SS countdown with BCD digits, done pulse and timed alarm
module countdown_timer #(
    parameter int MAX_MIN     = 99,
    parameter int ALARM_TICKS = 3
) (
    input logic              clk,
    input logic              rst_n,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int            CW    = $clog2(ALARM_TICKS + 1);
    localparam logic [6:0]    MAX_M = 7'(MAX_MIN);
    localparam logic [CW-1:0] LAST  = CW'(ALARM_TICKS);
    localparam logic [CW-1:0] ONE   = CW'(1);

    state_t        state_q;
    logic [6:0]    min_q;
    logic [5:0]    sec_q;
    logic          done_q;
    logic          alarm_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                state_q <= IDLE;
                min_q   <= '0;
                sec_q   <= '0;
                alarm_q <= 1'b0;
                cnt_q   <= '0;
            end else if (bus.load && state_q != RUNNING) begin
                state_q <= IDLE;
                min_q   <= (bus.load_min > MAX_M) ? MAX_M : bus.load_min;
                sec_q   <= (bus.load_sec > 6'd59) ? 6'd59 : bus.load_sec;
                alarm_q <= 1'b0;
                cnt_q   <= '0;
            end else if (bus.start && (state_q == IDLE || state_q == PAUSED)) begin
                if (min_q != '0 || sec_q != '0)
                    state_q <= RUNNING;
            end else if (bus.pause && state_q == RUNNING) begin
                state_q <= PAUSED;
            end else if (bus.tick && state_q == RUNNING) begin
                sec_q <= (sec_q != '0) ? sec_q - 6'd1 : 6'd59;
                if (sec_q == '0)
                    min_q <= min_q - 7'd1;
                // 00:01 is the only value whose decrement lands on 00:00
                if (min_q == '0 && sec_q == 6'd1) begin
                    state_q <= EXPIRED;
                    done_q  <= 1'b1;
                    alarm_q <= 1'b1;
                    cnt_q   <= '0;
                end
            end else if (bus.tick && state_q == EXPIRED) begin
                cnt_q <= cnt_q + ONE;
                if (cnt_q + ONE == LAST) begin
                    state_q <= IDLE;
                    alarm_q <= 1'b0;
                end
            end
        end
    end

    assign bus.state    = state_q;
    assign bus.min_tens = 4'(min_q / 7'd10);
    assign bus.min_ones = 4'(min_q % 7'd10);
    assign bus.sec_tens = 4'(sec_q / 6'd10);
    assign bus.sec_ones = 4'(sec_q % 6'd10);
    assign bus.done     = done_q;
    assign bus.alarm    = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random stimulus scored against a total-seconds reference model
module tb_countdown_timer;
    localparam int MAX_MIN     = 99;
    localparam int ALARM_TICKS = 3;

    typedef struct {
        int st;
        int mt;
        int mo;
        int stn;
        int so;
        int done;
        int alarm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    countdown_timer_if bus();

    countdown_timer #(.MAX_MIN(MAX_MIN), .ALARM_TICKS(ALARM_TICKS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: remaining time as a single count of seconds
    int m_st = 0, m_tot = 0, m_left = 0, m_alarm = 0, m_done = 0;

    task automatic model(input bit r, input bit t, input bit l, input bit s,
                         input bit p, input bit c, input int lm, input int ls);
        m_done = 0;
        if (!r) begin
            m_st = 0; m_tot = 0; m_alarm = 0; m_left = 0;
        end else if (c) begin
            m_st = 0; m_tot = 0; m_alarm = 0; m_left = 0;
        end else if (l && m_st != 1) begin
            m_tot   = (lm > MAX_MIN ? MAX_MIN : lm) * 60 + (ls > 59 ? 59 : ls);
            m_st    = 0;
            m_alarm = 0;
        end else if (s && (m_st == 0 || m_st == 2)) begin
            if (m_tot > 0) m_st = 1;
        end else if (p && m_st == 1) begin
            m_st = 2;
        end else if (t && m_st == 1) begin
            m_tot = m_tot - 1;
            if (m_tot == 0) begin
                m_st = 3; m_done = 1; m_alarm = 1; m_left = ALARM_TICKS;
            end
        end else if (t && m_st == 3) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_st = 0; m_alarm = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit l, input bit s,
                       input bit p, input bit c, input int lm = 0, input int ls = 0);
        exp_t e;
        int mm, ss;
        @(negedge clk);
        rst_n        = r;
        bus.tick     = t;
        bus.load     = l;
        bus.start    = s;
        bus.pause    = p;
        bus.clear    = c;
        bus.load_min = 7'(lm);
        bus.load_sec = 6'(ls);
        model(r, t, l, s, p, c, lm, ls);
        mm      = m_tot / 60;
        ss      = m_tot % 60;
        e.st    = m_st;
        e.mt    = mm / 10;
        e.mo    = mm % 10;
        e.stn   = ss / 10;
        e.so    = ss % 10;
        e.done  = m_done;
        e.alarm = m_alarm;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic tickn(input int n);
        idle(n - 1);
        cyc(1, 1, 0, 0, 0, 0);
    endtask

    task automatic load(input int lm, input int ls);
        cyc(1, 0, 1, 0, 0, 0, lm, ls);
    endtask

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, e, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",    8'(bus.state),    8'(e.st));
                chk("min_tens", 8'(bus.min_tens), 8'(e.mt));
                chk("min_ones", 8'(bus.min_ones), 8'(e.mo));
                chk("sec_tens", 8'(bus.sec_tens), 8'(e.stn));
                chk("sec_ones", 8'(bus.sec_ones), 8'(e.so));
                chk("done",     8'(bus.done),     8'(e.done));
                chk("alarm",    8'(bus.alarm),    8'(e.alarm));
            end
        end
    end

    initial begin
        bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0; bus.clear = 0;
        bus.load_min = '0; bus.load_sec = '0;
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        // basic expiry and alarm window
        load(0, 3);
        cyc(1, 0, 0, 1, 0, 0);
        repeat (6) tickn(10);
        idle(2);
        // minute borrow, full-range load and clamping
        load(1, 0);
        cyc(1, 0, 0, 1, 0, 0);
        tickn(10);
        cyc(1, 0, 0, 0, 0, 1);
        load(99, 59);
        load(120, 63);
        load(5, 0);
        // pause coinciding with a tick, then resume
        load(0, 10);
        cyc(1, 0, 0, 1, 0, 0);
        repeat (2) tickn(10);
        cyc(1, 1, 0, 0, 1, 0);
        repeat (2) tickn(5);
        cyc(1, 1, 0, 1, 0, 0);
        tickn(10);
        // start with zero loaded; load while running
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 0);
        idle(2);
        load(0, 6);
        cyc(1, 0, 0, 1, 0, 0);
        tickn(3);
        cyc(1, 1, 1, 0, 0, 0, 30, 0);
        tickn(3);
        load(0, 2);
        // clear while running and while expired
        cyc(1, 0, 0, 0, 1, 0);
        load(0, 6);
        cyc(1, 0, 0, 1, 0, 0);
        tickn(3);
        cyc(1, 0, 0, 0, 0, 1);
        idle(1);
        load(0, 1);
        cyc(1, 0, 0, 1, 0, 0);
        tickn(3);
        tickn(2);
        cyc(1, 0, 0, 0, 0, 1);
        idle(1);
        // reset mid-count
        load(0, 5);
        cyc(1, 0, 0, 1, 0, 0);
        tickn(4);
        cyc(0, 1, 0, 0, 0, 0);
        tickn(2);
        // random phase biased toward short presets so expiries occur
        for (int i = 0; i < 4000; i++) begin
            bit r, t, l, s, p, c;
            int lm, ls;
            r  = $urandom_range(0, 299) != 0;
            t  = $urandom_range(0, 2) == 0;
            l  = $urandom_range(0, 24) == 0;
            s  = $urandom_range(0, 7) == 0;
            p  = $urandom_range(0, 29) == 0;
            c  = $urandom_range(0, 79) == 0;
            lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
            ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
            cyc(r, t, l, s, p, c, lm, ls);
        end
        idle(1);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending entries", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
